// File: rtl/mux_esc_rafaga_if.sv
// Bus between the register-image bank, the channel mux and the RTC write sequencer.
// Output handshake: a byte on sal is transferred on a rising edge where valido && listo_in are both 1.
interface mux_esc_rafaga_if #(
    parameter int W  = 8,
    parameter int N  = 27,
    parameter int IW = 5
);
    logic           modo;
    logic [N-1:0]   sel;
    logic [N*W-1:0] ch;
    logic           inicio;
    logic [IW-1:0]  primero;
    logic [IW-1:0]  ultimo;
    logic           listo_in;
    logic           abortar;

    logic [W-1:0]   sal;
    logic           valido;
    logic [IW-1:0]  idx;
    logic [N-1:0]   sel_oh;
    logic           ocupado;
    logic           fin;
    logic           err_sel;
    logic [1:0]     estado_dbg;

    modport master (
        output modo, sel, ch, inicio, primero, ultimo, listo_in, abortar,
        input  sal, valido, idx, sel_oh, ocupado, fin, err_sel, estado_dbg
    );

    modport slave (
        input  modo, sel, ch, inicio, primero, ultimo, listo_in, abortar,
        output sal, valido, idx, sel_oh, ocupado, fin, err_sel, estado_dbg
    );
endinterface

// File: rtl/mux_esc_rafaga.sv
// Registered N-to-1 channel mux: direct one-hot select, or an autonomous burst
// over [primero..ultimo] that hands out one byte per valido/listo_in handshake.
module mux_esc_rafaga #(
    parameter int W  = 8,
    parameter int N  = 27,
    parameter int IW = 5
) (
    input  logic                clk,
    input  logic                reset,
    mux_esc_rafaga_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENVIA = 2'd1,
        FIN   = 2'd2
    } estado_t;

    estado_t        state_q, state_d;
    logic [W-1:0]   sal_q, sal_d;
    logic           valido_q, valido_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   sel_oh_q, sel_oh_d;
    logic [IW-1:0]  ultimo_q, ultimo_d;
    logic           fin_q, fin_d;
    logic           err_q, err_d;

    logic           sel_es_oh;
    logic [IW-1:0]  sel_idx;
    logic           rango_ok;
    logic [IW-1:0]  idx_inc;

    // Loop-based mux keeps every select in range, even for unused indices.
    function automatic logic [W-1:0] canal(input logic [N*W-1:0] c, input logic [IW-1:0] k);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (k == IW'(i)) r = c[i*W +: W];
        end
        return r;
    endfunction

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel[i]) sel_idx = IW'(i);
        end
    end

    assign sel_es_oh = (bus.sel != '0) && ((bus.sel & (bus.sel - N'(1))) == '0);
    assign rango_ok  = (bus.primero <= bus.ultimo) && (bus.ultimo <= IW'(N - 1));
    assign idx_inc   = idx_q + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sal_q    <= '0;
            valido_q <= 1'b0;
            idx_q    <= '0;
            sel_oh_q <= '0;
            ultimo_q <= '0;
            fin_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sal_q    <= sal_d;
            valido_q <= valido_d;
            idx_q    <= idx_d;
            sel_oh_q <= sel_oh_d;
            ultimo_q <= ultimo_d;
            fin_q    <= fin_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sal_d    = sal_q;
        valido_d = valido_q;
        idx_d    = idx_q;
        sel_oh_d = sel_oh_q;
        ultimo_d = ultimo_q;
        fin_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                valido_d = 1'b0;
                if (!bus.modo) begin
                    if (sel_es_oh) begin
                        sal_d    = canal(bus.ch, sel_idx);
                        idx_d    = sel_idx;
                        sel_oh_d = bus.sel;
                        valido_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.inicio) begin
                    if (rango_ok) begin
                        ultimo_d = bus.ultimo;
                        idx_d    = bus.primero;
                        sal_d    = canal(bus.ch, bus.primero);
                        sel_oh_d = N'(1) << bus.primero;
                        valido_d = 1'b1;
                        state_d  = ENVIA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ENVIA: begin
                // Abort takes priority over a simultaneous final handshake.
                if (bus.abortar) begin
                    valido_d = 1'b0;
                    state_d  = IDLE;
                end else if (valido_q && bus.listo_in) begin
                    if (idx_q == ultimo_q) begin
                        valido_d = 1'b0;
                        fin_d    = 1'b1;
                        state_d  = FIN;
                    end else begin
                        idx_d    = idx_inc;
                        sal_d    = canal(bus.ch, idx_inc);
                        sel_oh_d = sel_oh_q << 1;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                valido_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign bus.sal        = sal_q;
    assign bus.valido     = valido_q;
    assign bus.idx        = idx_q;
    assign bus.sel_oh     = sel_oh_q;
    assign bus.ocupado    = (state_q == ENVIA);
    assign bus.fin        = fin_q;
    assign bus.err_sel    = err_q;
    assign bus.estado_dbg = state_q;

    a_fin_en_fin : assert property (@(posedge clk) disable iff (!reset)
        fin_q |-> (state_q == FIN));
    a_envia_valido : assert property (@(posedge clk) disable iff (!reset)
        (state_q == ENVIA) |-> valido_q);
    a_err_en_idle : assert property (@(posedge clk) disable iff (!reset)
        err_q |-> (state_q == IDLE));

endmodule

// File: tb/tb_mux_esc_rafaga.sv
// Directed bench for mux_esc_rafaga: direct mode, bursts, bad ranges, abort and reset.
module tb_mux_esc_rafaga;
  localparam int W  = 8;
  localparam int N  = 27;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mux_esc_rafaga_if #(.W(W), .N(N), .IW(IW)) bus ();

  mux_esc_rafaga #(.W(W), .N(N), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_sal, input logic [IW-1:0] e_idx,
                           input logic e_val, input logic e_ocu, input logic e_fin, input logic e_err);
    check({tag, "_sal"}, bus.sal, e_sal);
    check({tag, "_idx"}, bus.idx, e_idx);
    check({tag, "_valido"}, bus.valido, e_val);
    check({tag, "_ocupado"}, bus.ocupado, e_ocu);
    check({tag, "_fin"}, bus.fin, e_fin);
    check({tag, "_err"}, bus.err_sel, e_err);
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    bus.ch[k*W +: W] = v;
  endtask

  initial begin
    reset        = 1'b0;
    bus.modo     = 1'b0;
    bus.sel      = '0;
    bus.inicio   = 1'b0;
    bus.primero  = '0;
    bus.ultimo   = '0;
    bus.listo_in = 1'b0;
    bus.abortar  = 1'b0;
    for (int k = 0; k < N; k++) set_ch(k, 8'(16 + k));

    // Reset state
    #3;
    check_out("rst", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_oh", bus.sel_oh, 32'h0);
    check("rst_st", bus.estado_dbg, 32'd0);
    step();
    step();
    reset = 1'b1;

    // Direct mode
    bus.sel = 27'h0000400;
    step();
    check_out("dir10", 8'h1A, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    check("dir10_oh", bus.sel_oh, 32'h400);
    bus.sel = 27'h4000000;
    step();
    check_out("dir26", 8'h2A, 5'd26, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.sel = 27'h0000400;
    step();
    bus.sel = 27'h0000006;
    step();
    check_out("dir_multi", 8'h1A, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    check("dir_multi_oh", bus.sel_oh, 32'h400);
    bus.sel = '0;
    step();
    check_out("dir_zero", 8'h1A, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.modo = 1'b1;
    step();
    check_out("dir_exit", 8'h1A, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Burst 0..6 with listo_in held high
    bus.primero  = 5'd0;
    bus.ultimo   = 5'd6;
    bus.inicio   = 1'b1;
    bus.listo_in = 1'b1;
    for (int i = 0; i <= 6; i++) exp_q.push_back(8'(16 + i));
    step();
    bus.inicio = 1'b0;
    check("b1_st", bus.estado_dbg, 32'd1);
    for (int i = 0; i <= 6; i++) begin
      check("b1_sal", bus.sal, exp_q.pop_front());
      check("b1_oh", bus.sel_oh, 32'd1 << i);
      check("b1_idx", bus.idx, i);
      check("b1_valido", bus.valido, 1'b1);
      check("b1_fin", bus.fin, 1'b0);
      step();
    end
    check_out("b1_fin", 8'h16, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b1_fin_st", bus.estado_dbg, 32'd2);
    bus.listo_in = 1'b0;
    step();
    check_out("b1_post", 8'h16, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b1_post_st", bus.estado_dbg, 32'd0);

    // Burst 24..26 with stalls and channel changes during stalls
    bus.primero = 5'd24;
    bus.ultimo  = 5'd26;
    bus.inicio  = 1'b1;
    step();
    bus.inicio = 1'b0;
    check_out("b2_h0", 8'h28, 5'd24, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.listo_in = 1'b1;
    step();
    check_out("b2_h1", 8'h29, 5'd25, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.listo_in = 1'b0;
    set_ch(25, 8'hAA);
    step();
    check_out("b2_stall1", 8'h29, 5'd25, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_out("b2_stall2", 8'h29, 5'd25, 1'b1, 1'b1, 1'b0, 1'b0);
    set_ch(25, 8'h29);
    bus.listo_in = 1'b1;
    step();
    check_out("b2_h2", 8'h2A, 5'd26, 1'b1, 1'b1, 1'b0, 1'b0);
    check("b2_h2_oh", bus.sel_oh, 32'h0400_0000);
    bus.listo_in = 1'b0;
    set_ch(26, 8'h55);
    step();
    check_out("b2_stall3", 8'h2A, 5'd26, 1'b1, 1'b1, 1'b0, 1'b0);
    set_ch(26, 8'h2A);
    bus.listo_in = 1'b1;
    step();
    check_out("b2_fin", 8'h2A, 5'd26, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.listo_in = 1'b0;
    step();
    check_out("b2_post", 8'h2A, 5'd26, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bad ranges
    bus.primero = 5'd7;
    bus.ultimo  = 5'd3;
    bus.inicio  = 1'b1;
    step();
    check_out("bad_rev", 8'h2A, 5'd26, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bad_rev_st", bus.estado_dbg, 32'd0);
    bus.inicio = 1'b0;
    step();
    check("bad_rev_pulse", bus.err_sel, 1'b0);
    bus.primero = 5'd0;
    bus.ultimo  = 5'd27;
    bus.inicio  = 1'b1;
    step();
    check_out("bad_max", 8'h2A, 5'd26, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.inicio = 1'b0;
    step();
    check("bad_max_pulse", bus.err_sel, 1'b0);

    // Single-channel burst at the top channel
    bus.primero  = 5'd26;
    bus.ultimo   = 5'd26;
    bus.inicio   = 1'b1;
    bus.listo_in = 1'b1;
    step();
    bus.inicio = 1'b0;
    check_out("one_ld", 8'h2A, 5'd26, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_out("one_fin", 8'h2A, 5'd26, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("one_post_fin", bus.fin, 1'b0);

    // Abort on the third handshake of burst 2..9, then immediate restart
    bus.primero = 5'd2;
    bus.ultimo  = 5'd9;
    bus.inicio  = 1'b1;
    step();
    bus.inicio = 1'b0;
    check_out("ab_ld", 8'h12, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    step();
    check_out("ab_h2", 8'h14, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.abortar = 1'b1;
    step();
    bus.abortar = 1'b0;
    check("ab_valido", bus.valido, 1'b0);
    check("ab_ocupado", bus.ocupado, 1'b0);
    check("ab_fin", bus.fin, 1'b0);
    check("ab_st", bus.estado_dbg, 32'd0);
    bus.primero = 5'd0;
    bus.ultimo  = 5'd1;
    bus.inicio  = 1'b1;
    step();
    bus.inicio = 1'b0;
    check_out("ab_restart", 8'h10, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_out("ab_r1", 8'h11, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("ab_r_fin", bus.fin, 1'b1);
    step();

    // Abort coinciding with the final handshake: abort wins
    bus.primero = 5'd5;
    bus.ultimo  = 5'd5;
    bus.inicio  = 1'b1;
    step();
    bus.inicio  = 1'b0;
    bus.abortar = 1'b1;
    step();
    bus.abortar = 1'b0;
    check("abfin_fin", bus.fin, 1'b0);
    check("abfin_st", bus.estado_dbg, 32'd0);
    step();
    check("abfin_fin2", bus.fin, 1'b0);

    // Asynchronous reset mid-burst at idx 5
    bus.primero = 5'd0;
    bus.ultimo  = 5'd10;
    bus.inicio  = 1'b1;
    step();
    bus.inicio = 1'b0;
    repeat (5) step();
    check("mid_idx", bus.idx, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check_out("arst", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_oh", bus.sel_oh, 32'h0);
    check("arst_st", bus.estado_dbg, 32'd0);
    step();
    reset = 1'b1;
    bus.listo_in = 1'b0;
    step();
    check_out("arst_post", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_post_st", bus.estado_dbg, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_esc_rafaga.md
Name: mux_esc_rafaga

Overview:
- Parametrised successor of the RTC write-data channel mux. It selects one W-bit channel out of N, and the output is registered.
- Two modes. Direct mode takes an external one-hot select and flags any select that is not one-hot. Burst mode walks a channel range [primero..ultimo] on its own and hands out one byte per valid/ready handshake.
- Sits between the register-image bank and the RTC bus write sequencer.

Parameters:
- W, 8, width of each channel and of sal.
- N, 27, number of channels.
- IW, 5, width of the index ports. Must satisfy 2^IW >= N.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- modo  in  1  0 = direct one-hot mode, 1 = burst mode. Sampled only in IDLE.
- sel  in  N  one-hot channel select, used in direct mode only.
- ch  in  N*W  packed channels. Channel k occupies bits [k*W +: W].
- inicio  in  1  burst start pulse, honoured only in IDLE with modo=1.
- primero  in  IW  first channel index of the burst.
- ultimo  in  IW  last channel index of the burst, inclusive.
- listo_in  in  1  downstream ready.
- abortar  in  1  cancels a burst in progress.
- sal  out  W  registered channel data.
- valido  out  1  sal is valid.
- idx  out  IW  index of the channel currently on sal.
- sel_oh  out  N  one-hot form of the channel currently on sal.
- ocupado  out  1  burst in progress (state ENVIA).
- fin  out  1  one-cycle pulse when the last byte of a burst is accepted.
- err_sel  out  1  one-cycle error pulse.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; sal=0, valido=0, idx=0, sel_oh=0, ocupado=0, fin=0, err_sel=0. Reset asserted mid-burst drops the burst immediately; no fin pulse is generated.
- States: IDLE, ENVIA, FIN.

Direct mode (IDLE, modo=0), one-cycle latency:
- sel exactly one-hot with bit k set: next edge sal<=ch[k], idx<=k, sel_oh<=sel, valido<=1.
- sel all-zero or multi-hot: sal, idx and sel_oh hold their values; valido<=0; err_sel<=1 for one cycle.
- listo_in is ignored in direct mode.

Burst start (IDLE, modo=1, inicio=1):
- Range check: primero<=ultimo and ultimo<=N-1.
- Range invalid: err_sel pulses for one cycle; stay in IDLE; valido<=0.
- Range valid: latch primero and ultimo. Next edge: idx<=primero, sal<=ch[primero], sel_oh<=1<<primero, valido<=1, ocupado<=1, go to ENVIA.
- In burst mode with inicio=0, IDLE holds sal, idx and sel_oh, and valido=0.

ENVIA:
- sal, idx and sel_oh stay stable while valido=1 and listo_in=0.
- On valido&listo_in with idx!=ultimo: same edge idx<=idx+1, sal<=ch[idx+1], sel_oh shifts left by one, valido stays 1. This gives back-to-back throughput of 1 byte per cycle.
- On valido&listo_in with idx==ultimo: valido<=0, ocupado<=0, fin<=1, go to FIN.
- Channel data is snapshotted at load time. A later change on ch does not alter a byte already presented.
- abortar=1: next edge valido<=0, ocupado<=0, go to IDLE, no fin. If abortar and the final handshake occur in the same cycle, abortar wins and fin is not pulsed.
- inicio, modo and sel are ignored while in ENVIA or FIN.

FIN:
- Lasts exactly one cycle, with fin=1; then go to IDLE with fin<=0.
- sal, idx and sel_oh keep the last byte's values.

Single-channel burst (primero==ultimo):
- One byte is presented; the handshake leads to FIN.

Index arithmetic:
- IW bits, no wrap. Increment only occurs while idx<ultimo<=N-1.

Test Plan:
- Reset: assert reset=0 mid-burst (idx=5) -> all outputs 0 asynchronously, state IDLE, no fin pulse.
- Direct mode: N=27, ch[k]=8'h10+k, sel=27'h0000400 -> one cycle later sal=8'h1A, idx=10, valido=1. Then sel=27'h0000006 -> err_sel pulses once, valido=0, sal holds 8'h1A.
- Burst with listo_in held 1: primero=0, ultimo=6 -> sal=8'h10..8'h16 on 7 consecutive cycles, sel_oh runs 1..64, fin pulses once on the cycle after the byte 8'h16 is accepted.
- Burst with listo_in toggling 1,0,0,1,...: primero=24, ultimo=26 -> each byte held stable during stall cycles, exactly 3 handshakes, fin once, ch changes during a stall have no effect on the held sal.
- Bad range: primero=7, ultimo=3 (and separately ultimo=27) -> err_sel pulses for one cycle, ocupado stays 0, no valido.
- Abort: abortar asserted on the cycle of the 3rd handshake of a burst 2..9 -> valido=0, ocupado=0 next cycle, no fin. A new inicio is accepted on the following cycle.
